// File: rtl/pipe_skid_stage_pkg.sv
// Shared encodings for the skid stage: occupancy states, truth values, reset level, default widths.
// Purely declarative; no latency or backpressure of its own.
package pipe_skid_stage_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    localparam logic TRUE       = 1'b1;
    localparam logic FALSE      = 1'b0;
    localparam logic RST_ACTIVE = 1'b1;

    localparam int DATA_W_DEF = 128;
    localparam int CNT_W_DEF  = 32;

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating event counter; 1-cycle update latency, clear beats increment.
// No backpressure: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);
    import pipe_skid_stage_pkg::*;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i == RST_ACTIVE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with 2-entry skid, flush and perf counters; 1-cycle latency.
// Backpressure: up_ready_out is registered and drops only when both entries are held.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int                DATA_W  = DATA_W_DEF,
    parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W   = CNT_W_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              flush_in,
    input  logic              up_valid_in,
    output logic              up_ready_out,
    input  logic [DATA_W-1:0] up_data_in,
    output logic              dn_valid_out,
    input  logic              dn_ready_in,
    output logic [DATA_W-1:0] dn_data_out,
    output logic [1:0]        occupancy_out,
    output logic [CNT_W-1:0]  starve_cnt_out,
    output logic [CNT_W-1:0]  stall_cnt_out,
    input  logic              cnt_clr_in
);

    occ_e              state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              up_rdy_q, up_rdy_d;
    logic              dn_vld_q, dn_vld_d;
    logic              up_fire;
    logic              dn_fire;

    assign up_fire = up_valid_in & up_rdy_q;
    assign dn_fire = dn_vld_q & dn_ready_in;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            OCC_EMPTY: begin
                if (up_fire) begin
                    main_d  = up_data_in;
                    state_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (up_fire && dn_fire) begin
                    main_d = up_data_in;
                end else if (up_fire) begin
                    skid_d  = up_data_in;
                    state_d = OCC_FULL;
                end else if (dn_fire) begin
                    main_d  = NOP_VAL;
                    state_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (dn_fire) begin
                    main_d  = skid_q;
                    skid_d  = NOP_VAL;
                    state_d = OCC_ONE;
                end
            end
            default: begin
                state_d = OCC_EMPTY;
                main_d  = NOP_VAL;
                skid_d  = NOP_VAL;
            end
        endcase
        // Kill wins over any load, including a same-cycle upstream transfer.
        if (flush_in) begin
            state_d = OCC_EMPTY;
            main_d  = NOP_VAL;
            skid_d  = NOP_VAL;
        end
        up_rdy_d = (state_d != OCC_FULL);
        dn_vld_d = (state_d != OCC_EMPTY);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in == RST_ACTIVE) begin
            state_q  <= OCC_EMPTY;
            main_q   <= NOP_VAL;
            skid_q   <= NOP_VAL;
            up_rdy_q <= TRUE;
            dn_vld_q <= FALSE;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            up_rdy_q <= up_rdy_d;
            dn_vld_q <= dn_vld_d;
        end
    end

    assign up_ready_out  = up_rdy_q;
    assign dn_valid_out  = dn_vld_q;
    assign dn_data_out   = main_q;
    assign occupancy_out = state_q;

    sat_counter #(.CNT_W(CNT_W)) u_starve_cnt (
        .clk_i (clk_in),
        .rst_i (rst_in),
        .inc_i (dn_ready_in & ~dn_vld_q),
        .clr_i (cnt_clr_in),
        .cnt_o (starve_cnt_out)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i (clk_in),
        .rst_i (rst_in),
        .inc_i (dn_vld_q & ~dn_ready_in),
        .clr_i (cnt_clr_in),
        .cnt_o (stall_cnt_out)
    );

endmodule
